// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM states, redirect sources and the
// sequential fetch increment.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    HALT  = 3'd3
  } state_e;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_TRAP   = 3'd1,
    SRC_JALR   = 3'd2,
    SRC_JAL    = 3'd3,
    SRC_BRANCH = 3'd4
  } src_e;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect source selection and target computation. Execute targets are
// alignment/bounds checked; an illegal one is dropped and flagged, never demoted.
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] MAX_PC     = 32'h0000_0100
) (
  input  logic                  trap_req,
  input  logic                  exec_en,
  input  logic                  ex_valid,
  input  logic                  ex_branch_taken,
  input  logic                  ex_jal,
  input  logic                  ex_jalr,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] ex_rs1,
  input  logic [DATA_WIDTH-1:0] trap_vec,
  output src_e                  src_o,
  output logic [DATA_WIDTH-1:0] target_o,
  output logic                  target_err_o
);

  logic [DATA_WIDTH-1:0] jalr_sum;
  logic [DATA_WIDTH-1:0] rel_sum;
  logic [DATA_WIDTH-1:0] cand;
  src_e                  cand_src;
  logic                  cand_bad;

  assign jalr_sum = ex_rs1 + ex_imm;
  assign rel_sum  = ex_pc + ex_imm;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave a value unassigned (latch).
  always_comb begin
    cand     = '0;
    cand_src = SRC_NONE;
    if (exec_en && ex_valid) begin
      if (ex_jalr) begin
        cand     = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
        cand_src = SRC_JALR;
      end else if (ex_jal) begin
        cand     = rel_sum;
        cand_src = SRC_JAL;
      end else if (ex_branch_taken) begin
        cand     = rel_sum;
        cand_src = SRC_BRANCH;
      end
    end
  end

  assign cand_bad = (cand > MAX_PC) || (cand[1:0] != 2'b00);

  always_comb begin
    src_o        = SRC_NONE;
    target_o     = '0;
    target_err_o = 1'b0;
    if (trap_req) begin
      src_o    = SRC_TRAP;
      target_o = trap_vec;
    end else if (cand_src != SRC_NONE) begin
      if (cand_bad) begin
        target_err_o = 1'b1;
      end else begin
        src_o    = cand_src;
        target_o = cand;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: one prioritised PC decision per cycle plus flush
// strobes. Define PC_SEQ_PERF_CNT_EN to build the redirect/stall counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] MAX_PC       = 32'h0000_0100,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                    FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_cur,
  output logic                  imem_req,
  input  logic                  imem_ready,
  input  logic                  hazard_stall,
  input  logic                  ex_valid,
  input  logic                  ex_branch_taken,
  input  logic                  ex_jal,
  input  logic                  ex_jalr,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] ex_rs1,
  input  logic                  trap_req,
  input  logic [DATA_WIDTH-1:0] trap_vec,
  input  logic                  halt_req,
  output logic                  pc_write,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic                  target_err,
  output logic [2:0]            state_o,
  output logic [31:0]           redirect_count,
  output logic [31:0]           stall_count
);

  localparam int              CNT_W        = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam bit              LONG_FLUSH   = (FLUSH_CYCLES > 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  src_e                  src;
  logic [DATA_WIDTH-1:0] target;
  logic                  tgt_err;
  logic [DATA_WIDTH:0]   seq_pc_wide;
  logic                  seq_ok;
  logic                  flush;

  pc_target_calc #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_PC    (MAX_PC)
  ) u_target_calc (
    .trap_req       (trap_req),
    .exec_en        (state_q == RUN),
    .ex_valid       (ex_valid),
    .ex_branch_taken(ex_branch_taken),
    .ex_jal         (ex_jal),
    .ex_jalr        (ex_jalr),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .trap_vec       (trap_vec),
    .src_o          (src),
    .target_o       (target),
    .target_err_o   (tgt_err)
  );

  // One extra bit so a wrapping pc_cur+4 cannot sneak under MAX_PC.
  assign seq_pc_wide = {1'b0, pc_cur} + (DATA_WIDTH+1)'(PC_INCR);
  assign seq_ok      = (seq_pc_wide <= {1'b0, MAX_PC});

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    imem_req    = 1'b0;
    pc_write    = 1'b0;
    next_pc     = seq_pc_wide[DATA_WIDTH-1:0];
    flush       = 1'b0;
    target_err  = 1'b0;
    if (!rst_n) begin
      next_pc = RESET_PC;
    end else begin
      unique case (state_q)
        BOOT: begin
          pc_write = 1'b1;
          next_pc  = RESET_PC;
          state_d  = RUN;
        end
        RUN, FLUSH: begin
          imem_req = 1'b1;
          if (state_q == FLUSH) begin
            flush = 1'b1;
            if (flush_cnt_q <= CNT_W'(1)) state_d = RUN;
            else                          flush_cnt_d = flush_cnt_q - CNT_W'(1);
          end
          if (src != SRC_NONE) begin
            pc_write    = 1'b1;
            next_pc     = target;
            flush       = 1'b1;
            state_d     = LONG_FLUSH ? FLUSH : RUN;
            flush_cnt_d = FLUSH_RELOAD;
          end else if (tgt_err) begin
            target_err = 1'b1;
          end else begin
            pc_write = imem_ready & ~hazard_stall & seq_ok;
          end
          if (halt_req && !trap_req && !tgt_err) state_d = HALT;
        end
        HALT: begin
          if (src == SRC_TRAP) begin
            pc_write    = 1'b1;
            next_pc     = target;
            flush       = 1'b1;
            state_d     = LONG_FLUSH ? FLUSH : RUN;
            flush_cnt_d = FLUSH_RELOAD;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign flush_if = flush;
  assign flush_id = flush;
  assign state_o  = state_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] redirect_count_q, redirect_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        redirect_fire;

  // Any write outside BOOT not explained by sequential fetch is a redirect.
  assign redirect_fire = pc_write && (src != SRC_NONE) && (state_q != BOOT);

  always_comb begin
    redirect_count_d = redirect_count_q + {31'd0, redirect_fire};
    stall_count_d    = stall_count_q + {31'd0, (imem_req && !pc_write)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_count_q <= '0;
      stall_count_q    <= '0;
    end else begin
      redirect_count_q <= redirect_count_d;
      stall_count_q    <= stall_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
  assign stall_count    = stall_count_q;
`else
  assign redirect_count = '0;
  assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam logic [31:0] MAX_PC   = 32'h0000_0100;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FC       = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cur;
  logic        imem_req, imem_ready, hazard_stall;
  logic        ex_valid, ex_branch_taken, ex_jal, ex_jalr;
  logic [31:0] ex_pc, ex_imm, ex_rs1, trap_vec;
  logic        trap_req, halt_req;
  logic        pc_write, flush_if, flush_id, target_err;
  logic [31:0] next_pc, redirect_count, stall_count;
  logic [2:0]  state_o;

  pc_sequencer #(
    .DATA_WIDTH  (32),
    .MAX_PC      (MAX_PC),
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur),
    .imem_req(imem_req), .imem_ready(imem_ready), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .trap_req(trap_req), .trap_vec(trap_vec), .halt_req(halt_req),
    .pc_write(pc_write), .next_pc(next_pc), .flush_if(flush_if), .flush_id(flush_id),
    .target_err(target_err), .state_o(state_o),
    .redirect_count(redirect_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
  endtask

  // Model state: cycle index, booting/halted flags, last cycle with flush high.
  bit          m_boot, m_halt;
  int          m_cyc, m_flush_end;
  logic [31:0] m_redir, m_stall, pc_reg;
  // Per-cycle expectations and pending updates.
  bit          e_pw, e_imem, e_flush, e_err, n_halt, inc_r, inc_s;
  logic [31:0] e_next;
  int          n_fe;

  task automatic idle();
    imem_ready = 1'b1; hazard_stall = 1'b0; ex_valid = 1'b0;
    ex_branch_taken = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    trap_req = 1'b0; trap_vec = '0; halt_req = 1'b0;
  endtask

  task automatic eval_cycle();
    bit          have, legal, chk_next, in_flush;
    logic [31:0] t, sum;
    logic [32:0] seq;
    rst_n  = 1'b1;
    pc_cur = pc_reg;
    #1;
    e_pw = 0; e_imem = 0; e_flush = 0; e_err = 0; chk_next = 0; e_next = '0;
    n_halt = m_halt; n_fe = m_flush_end; inc_r = 0; inc_s = 0;
    have = 0; legal = 1; t = '0;
    in_flush = (m_cyc <= m_flush_end);
    if (m_boot) begin
      e_pw = 1; e_next = RESET_PC; chk_next = 1;
    end else if (m_halt) begin
      if (trap_req) begin
        e_pw = 1; e_next = trap_vec; e_flush = 1; chk_next = 1;
        n_halt = 0; n_fe = m_cyc + FC - 1; inc_r = 1;
      end
    end else begin
      e_imem  = 1;
      e_flush = in_flush;
      if (trap_req) begin
        have = 1; t = trap_vec;
      end else if (!in_flush && ex_valid) begin
        if (ex_jalr) begin
          sum = ex_rs1 + ex_imm; t = sum & ~32'h1; have = 1;
        end else if (ex_jal || ex_branch_taken) begin
          t = ex_pc + ex_imm; have = 1;
        end
        if (have && (t > MAX_PC || t[1:0] != 2'b00)) legal = 0;
      end
      if (have && legal) begin
        e_pw = 1; e_next = t; e_flush = 1; chk_next = 1;
        n_fe = m_cyc + FC - 1; inc_r = 1;
      end else if (have) begin
        e_err = 1;
      end else begin
        seq = {1'b0, pc_reg} + 33'd4;
        e_next = seq[31:0]; chk_next = 1;
        e_pw = imem_ready && !hazard_stall && (seq <= {1'b0, MAX_PC});
      end
      if (halt_req && !trap_req && !(have && !legal)) begin
        n_halt = 1; n_fe = -1;
      end
      inc_s = !e_pw;
    end
    check("pc_write", {31'd0, pc_write}, {31'd0, e_pw});
    check("imem_req", {31'd0, imem_req}, {31'd0, e_imem});
    check("flush_if", {31'd0, flush_if}, {31'd0, e_flush});
    check("flush_id", {31'd0, flush_id}, {31'd0, e_flush});
    check("target_err", {31'd0, target_err}, {31'd0, e_err});
    if (chk_next) check("next_pc", next_pc, e_next);
`ifdef PC_SEQ_PERF_CNT_EN
    check("redirect_count", redirect_count, m_redir);
    check("stall_count", stall_count, m_stall);
`else
    check("redirect_count", redirect_count, 32'd0);
    check("stall_count", stall_count, 32'd0);
`endif
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (e_pw) pc_reg = e_next;
    m_boot = 0; m_halt = n_halt; m_flush_end = n_fe;
    m_redir = m_redir + {31'd0, inc_r};
    m_stall = m_stall + {31'd0, inc_s};
    m_cyc++;
  endtask

  task automatic step_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); idle(); eval_cycle(); finish_cycle();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_pc_write", {31'd0, pc_write}, 32'd0);
    check("rst_next_pc", next_pc, RESET_PC);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_flush", {30'd0, flush_if, flush_id}, 32'd0);
    check("rst_target_err", {31'd0, target_err}, 32'd0);
    check("rst_state", 32'(state_o), 32'(BOOT));
    check("rst_redirect_count", redirect_count, 32'd0);
    check("rst_stall_count", stall_count, 32'd0);
    @(posedge clk);
    m_boot = 1; m_halt = 0; m_flush_end = -1;
    m_redir = '0; m_stall = '0; pc_reg = RESET_PC;
  endtask

  task automatic rand_inputs();
    ex_valid        = ($urandom_range(0, 1) == 1);
    ex_branch_taken = ($urandom_range(0, 3) == 0);
    ex_jal          = ($urandom_range(0, 3) == 0);
    ex_jalr         = ($urandom_range(0, 3) == 0);
    ex_pc           = 32'($urandom_range(0, 63)) * 4;
    case ($urandom_range(0, 7))
      0:       ex_imm = 32'($urandom_range(0, 3));
      1:       ex_imm = 32'h0000_0100;
      2:       ex_imm = 32'hFFFF_FFF0;
      default: ex_imm = 32'($urandom_range(0, 31)) * 4;
    endcase
    ex_rs1       = 32'($urandom_range(0, 64)) * 4 + 32'($urandom_range(0, 1));
    trap_req     = ($urandom_range(0, 15) == 0);
    trap_vec     = 32'($urandom_range(0, 72)) * 4;
    halt_req     = ($urandom_range(0, 99) == 0);
    hazard_stall = ($urandom_range(0, 3) == 0);
    imem_ready   = ($urandom_range(0, 3) != 0);
  endtask

  logic [31:0] bad_tgts [2] = '{32'h0000_0102, 32'h0000_0200};

  initial begin
    idle();
    pc_reg = RESET_PC; pc_cur = RESET_PC;
    m_cyc = 0;
    apply_reset();

    // Boot then straight-line fetch.
    @(negedge clk); idle(); eval_cycle();
    check("boot_next_pc", next_pc, 32'h0);
    finish_cycle();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); idle(); eval_cycle();
      check("seq_next_pc", next_pc, 32'(i * 4));
      check("seq_flush", {31'd0, flush_if}, 32'd0);
      finish_cycle();
    end

    // Taken branch overrides a stall; second branch during flush is ignored.
    @(negedge clk); idle();
    ex_valid = 1; ex_branch_taken = 1; ex_pc = 32'h10; ex_imm = 32'h20; hazard_stall = 1;
    eval_cycle();
    check("br_next_pc", next_pc, 32'h30);
    check("br_pc_write", {31'd0, pc_write}, 32'd1);
    finish_cycle();
    @(negedge clk); idle();
    ex_valid = 1; ex_branch_taken = 1; ex_pc = 32'h0; ex_imm = 32'h40;
    eval_cycle();
    check("br_ignored_next_pc", next_pc, 32'h34);
    check("br_ignored_flush", {31'd0, flush_if}, 32'd1);
    finish_cycle();
    @(negedge clk); idle(); eval_cycle();
    check("flush_over", {31'd0, flush_if}, 32'd0);
    finish_cycle();

    // JALR beats JAL; bit 0 of the sum is dropped.
    @(negedge clk); idle();
    ex_valid = 1; ex_jalr = 1; ex_jal = 1; ex_rs1 = 32'h41; ex_imm = 32'h4; ex_pc = 32'h80;
    eval_cycle();
    check("jalr_next_pc", next_pc, 32'h44);
    finish_cycle();
    step_idle(2);

    // Misaligned and out-of-range branch targets.
    foreach (bad_tgts[k]) begin
      @(negedge clk); idle();
      ex_valid = 1; ex_branch_taken = 1; ex_pc = 32'h100; ex_imm = bad_tgts[k] - 32'h100;
      eval_cycle();
      check("bad_tgt_err", {31'd0, target_err}, 32'd1);
      check("bad_tgt_pc_write", {31'd0, pc_write}, 32'd0);
      finish_cycle();
    end

    // Three stalled cycles, then a trap during the stall.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); hazard_stall = 1; eval_cycle();
      check("stall_next_pc", next_pc, 32'h50);
      finish_cycle();
    end
    @(negedge clk); idle(); hazard_stall = 1; trap_req = 1; trap_vec = 32'h80;
    eval_cycle();
    check("trap_stall_next_pc", next_pc, 32'h80);
    finish_cycle();
    step_idle(3);

    // Last legal PC, then sequential fetch stops at MAX_PC.
    @(negedge clk); idle(); trap_req = 1; trap_vec = 32'hFC; eval_cycle(); finish_cycle();
    @(negedge clk); idle(); eval_cycle();
    check("max_pc_write", {31'd0, pc_write}, 32'd1);
    finish_cycle();
    @(negedge clk); idle(); eval_cycle();
    check("past_max_pc_write", {31'd0, pc_write}, 32'd0);
    finish_cycle();

    // Halt, then trap out of HALT.
    apply_reset();
    step_idle(3);
    @(negedge clk); idle(); halt_req = 1; eval_cycle(); finish_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); eval_cycle();
      check("halt_imem_req", {31'd0, imem_req}, 32'd0);
      finish_cycle();
    end
    @(negedge clk); idle(); trap_req = 1; trap_vec = 32'h80; eval_cycle();
    check("halt_trap_next_pc", next_pc, 32'h80);
    finish_cycle();
    @(negedge clk); idle(); eval_cycle();
    check("post_halt_next_pc", next_pc, 32'h84);
`ifdef PC_SEQ_PERF_CNT_EN
    check("post_halt_redirects", redirect_count, 32'd1);
`endif
    finish_cycle();

    // Reset in the middle of a flush window.
    step_idle(2);
    @(negedge clk); idle(); ex_valid = 1; ex_jal = 1; ex_pc = 32'h20; ex_imm = 32'h8;
    eval_cycle(); finish_cycle();
    apply_reset();
    step_idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      @(negedge clk); idle(); rand_inputs(); eval_cycle(); finish_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control block sequencing the program counter register in the fetch stage. Arbitrates PC redirect requests from execute (branch, JAL, JALR) and the trap unit. Combines them with hazard stalls and the instruction-memory handshake to produce the PC write enable, the next-PC value and pipeline flush strobes. Sits between execute/hazard logic and the PC register, replacing ad-hoc per-source enables with one prioritised decision per cycle.

## Interface
- DATA_WIDTH, 32, address/data width
- MAX_PC, 32'h00000100, highest legal PC (inclusive)
- RESET_PC, 32'h00000000, PC value presented after reset
- FLUSH_CYCLES, 2, cycles flush_if/flush_id stay high per redirect (>=1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, synchronous and active-low
- pc_cur  in  DATA_WIDTH  current PC register value
- imem_req  out  1  fetch request to instruction memory
- imem_ready  in  1  instruction memory accepted fetch this cycle
- hazard_stall  in  1  load-use/structural stall from hazard unit
- ex_valid  in  1  execute-stage instruction valid
- ex_branch_taken, ex_jal, ex_jalr  in  1 each  resolved control-flow type
- ex_pc, ex_imm, ex_rs1  in  DATA_WIDTH  execute PC, immediate, rs1 data
- trap_req  in  1  trap/exception request
- trap_vec  in  DATA_WIDTH  trap target (not bounds-checked)
- halt_req  in  1  stop fetching (e.g. ECALL/EBREAK end-of-test)
- pc_write  out  1  PC register load enable
- next_pc  out  DATA_WIDTH  value loaded into PC when pc_write=1
- flush_if, flush_id  out  1  squash IF/ID and ID/EX contents
- target_err  out  1  one-cycle pulse: illegal redirect target dropped
- state_o  out  3  current FSM state (debug)
- redirect_count, stall_count  out  32  performance counters (see Configuration)

## Operation
- States: BOOT, RUN, FLUSH, HALT. BOOT lasts one cycle after reset release, then RUN.
- Redirect sources, priority high->low: trap_req, ex_jalr, ex_jal, ex_branch_taken. Execute sources count only with ex_valid=1.
- Targets: JALR = (ex_rs1+ex_imm) with bit0 cleared; JAL/branch = ex_pc+ex_imm; trap = trap_vec. Sums modulo 2^DATA_WIDTH, wrap silently.
- Execute target illegal if > MAX_PC or [1:0]!=0: target_err=1, no redirect, pc_write=0, state unchanged. Next lower source is not considered.
- RUN, no redirect: imem_req=1. pc_write=imem_ready & ~hazard_stall; next_pc=pc_cur+4. If pc_cur+4 > MAX_PC: pc_write=0.
- RUN, legal redirect: pc_write=1 and next_pc=target regardless of hazard_stall/imem_ready, flush_if=flush_id=1. Goes to FLUSH if FLUSH_CYCLES>1, else stays RUN.
- FLUSH: flush_if=flush_id=1; execute redirects ignored (wrong path); trap still honoured and restarts the count. Sequential fetch continues as in RUN. Returns to RUN after FLUSH_CYCLES-1 cycles.
- halt_req in RUN/FLUSH (no trap same cycle) -> HALT. HALT: imem_req=0, pc_write=0, flushes 0. Only trap_req (redirect, -> FLUSH) or reset exits.
- trap_req and halt_req together: trap wins.
- Reset values: pc_write=0, next_pc=RESET_PC, imem_req=0, flush_if=flush_id=0, target_err=0, state BOOT, counters 0.
- BOOT: pc_write=1, next_pc=RESET_PC, imem_req=0.
- Reset mid-FLUSH: count cleared, pending flush abandoned.

## Timing
- Outputs combinational from registered state plus current inputs; zero-cycle decision latency.
- Redirect seen in cycle N -> PC holds target after edge ending N. Flushes high cycles N..N+FLUSH_CYCLES-1.
- FLUSH counter: registered, ceil(log2(FLUSH_CYCLES))+1 bits.
- imem handshake: fetch completes in the cycle imem_req & imem_ready; no request is held across HALT.

## Configuration
- PC_SEQ_PERF_CNT_EN defined: redirect_count increments per accepted redirect; stall_count increments per RUN/FLUSH cycle with imem_req=1 and pc_write=0. Both wrap at 2^32, cleared by reset.
- Undefined: counters not built, both outputs tied to 0.

## Structure
- pc_seq_pkg: state enum (BOOT, RUN, FLUSH, HALT), redirect-source enum (NONE, TRAP, JALR, JAL, BRANCH), PC_INCR=4.
- Sub-module pc_target_calc: combinational source select, target add, alignment/bounds check, target_err.

## Test plan
- Reset release, imem_ready=1, pc_cur tracks next_pc: cycle 1 next_pc=0; then 0x4, 0x8, 0xC; flushes 0.
- Branch at ex_pc=0x10, imm=0x20 -> next_pc=0x30, pc_write=1, flushes high 2 cycles. Branch in 2nd flush cycle ignored.
- JALR ex_rs1=0x41, imm=0x4 -> next_pc=0x44. JALR with JAL together -> JALR target used.
- Branch to 0x102 or 0x200 -> target_err pulse, pc_write=0, PC unchanged, no flush.
- hazard_stall=1 for 3 cycles -> pc_write=0 x3, next_pc held. Trap to 0x80 during stall -> immediate redirect to 0x80.
- halt_req -> HALT, imem_req=0 forever. Trap 0x80 -> FLUSH, fetch at 0x80. With PC_SEQ_PERF_CNT_EN, redirect_count=1.
